// File: rtl/multicycle_control_unit_if.sv
// Control-side bundle of the multi-cycle control unit: memory handshake in,
// datapath selects, strobes and status out.
interface multicycle_control_unit_if #(
    parameter int OPCODE_WIDTH = 3,
    parameter int COUNT_WIDTH  = 16
);
    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    memReady;
    logic                    aluSelect;
    logic                    regSelect;
    logic                    immSelect;
    logic                    dataSelect;
    logic                    muxSelect;
    logic                    jumpSelect;
    logic                    memRead;
    logic                    memWrite;
    logic                    irWrite;
    logic                    pcWrite;
    logic                    regWrite;
    logic                    trap;
    logic [2:0]              state;
    logic [COUNT_WIDTH-1:0]  instrCount;

    // The control unit itself.
    modport master (
        input  opcode, memReady,
        output aluSelect, regSelect, immSelect, dataSelect, muxSelect, jumpSelect,
        output memRead, memWrite, irWrite, pcWrite, regWrite,
        output trap, state, instrCount
    );

    // The memory/datapath side that consumes the controls.
    modport slave (
        output opcode, memReady,
        input  aluSelect, regSelect, immSelect, dataSelect, muxSelect, jumpSelect,
        input  memRead, memWrite, irWrite, pcWrite, regWrite,
        input  trap, state, instrCount
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: walks each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, waits on memReady with an optional
// timeout that traps, and counts retired instructions.
module multicycle_control_unit #(
    parameter int OPCODE_WIDTH = 3,
    parameter int MEM_TIMEOUT  = 16,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_control_unit_if.master bus
);
    // Wide enough to hold MEM_TIMEOUT-1, the largest value ever stored.
    localparam int WAIT_WIDTH = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } stateType;

    stateType                stateReg, stateNext;
    logic [OPCODE_WIDTH-1:0] irReg, irNext;
    logic [WAIT_WIDTH-1:0]   waitCountReg, waitCountNext;
    logic [COUNT_WIDTH-1:0]  instrCountReg, instrCountNext;

    logic [2:0] op;
    logic       upperBits;
    logic       timeoutHit;
    logic       isNop, isLw, isSw, isJump, isAdd, isAddi, isSub, isLegal;

    // Raw controls before the reset override.
    logic aluRaw, regRaw, immRaw, dataRaw, muxRaw, jumpRaw;
    logic memReadRaw, memWriteRaw, irWriteRaw, pcWriteRaw, regWriteRaw;
    logic retire;

    assign op = irReg[2:0];

    // Any set bit above the 3-bit opcode field makes the instruction illegal.
    generate
        if (OPCODE_WIDTH > 3) begin : gUpperBits
            assign upperBits = |irReg[OPCODE_WIDTH-1:3];
        end else begin : gNoUpperBits
            assign upperBits = 1'b0;
        end
    endgenerate

    // A timeout of zero means wait for memory forever.
    generate
        if (MEM_TIMEOUT > 0) begin : gTimeout
            assign timeoutHit = !bus.memReady &&
                                (waitCountReg == WAIT_WIDTH'(MEM_TIMEOUT - 1));
        end else begin : gNoTimeout
            assign timeoutHit = 1'b0;
        end
    endgenerate

    assign isNop   = (op == 3'b000);
    assign isLw    = (op == 3'b001);
    assign isSw    = (op == 3'b010);
    assign isJump  = (op == 3'b011);
    assign isAdd   = (op == 3'b100);
    assign isAddi  = (op == 3'b101);
    assign isSub   = (op == 3'b110);
    assign isLegal = !upperBits && (op != 3'b111);

    // Next-state, control decode and bookkeeping for the current cycle.
    always_comb begin
        stateNext   = stateReg;
        irNext      = irReg;
        aluRaw      = 1'b0;
        regRaw      = 1'b0;
        immRaw      = 1'b0;
        dataRaw     = 1'b0;
        muxRaw      = 1'b0;
        jumpRaw     = 1'b0;
        memReadRaw  = 1'b0;
        memWriteRaw = 1'b0;
        irWriteRaw  = 1'b0;
        pcWriteRaw  = 1'b0;
        regWriteRaw = 1'b0;
        retire      = 1'b0;

        // ALU/register/immediate selects follow the instruction once it is past decode.
        if (stateReg == EXECUTE || stateReg == MEMORY || stateReg == WRITEBACK) begin
            aluRaw = isSub;
            regRaw = isAdd || isSub;
            immRaw = isLw || isSw || isAddi;
        end

        case (stateReg)
            FETCH: begin
                memReadRaw = 1'b1;
                if (bus.memReady) begin
                    irNext     = bus.opcode;
                    irWriteRaw = 1'b1;
                    pcWriteRaw = 1'b1;
                    stateNext  = DECODE;
                end else if (timeoutHit) begin
                    stateNext = TRAP;
                end
            end
            DECODE: begin
                if (!isLegal) begin
                    stateNext = TRAP;
                end else if (isNop) begin
                    stateNext = FETCH;
                    retire    = 1'b1;
                end else begin
                    stateNext = EXECUTE;
                end
            end
            EXECUTE: begin
                if (isJump) begin
                    pcWriteRaw = 1'b1;
                    jumpRaw    = 1'b1;
                    stateNext  = FETCH;
                    retire     = 1'b1;
                end else if (isLw || isSw) begin
                    stateNext = MEMORY;
                end else if (isAdd || isAddi || isSub) begin
                    stateNext = WRITEBACK;
                end else begin
                    stateNext = FETCH;
                end
            end
            MEMORY: begin
                muxRaw      = 1'b1;
                immRaw      = 1'b1;
                memReadRaw  = isLw;
                memWriteRaw = isSw;
                if (bus.memReady) begin
                    if (isLw) begin
                        stateNext = WRITEBACK;
                    end else begin
                        stateNext = FETCH;
                        retire    = isSw;
                    end
                end else if (timeoutHit) begin
                    stateNext = TRAP;
                end
            end
            WRITEBACK: begin
                regWriteRaw = 1'b1;
                dataRaw     = isLw;
                stateNext   = FETCH;
                retire      = 1'b1;
            end
            TRAP: begin
                stateNext = TRAP;
            end
            default: begin
                stateNext = TRAP;
            end
        endcase

        // Count only consecutive stalled cycles within one FETCH or MEMORY visit.
        waitCountNext = '0;
        if (MEM_TIMEOUT > 0 && (stateReg == FETCH || stateReg == MEMORY) &&
            !bus.memReady && stateNext == stateReg) begin
            waitCountNext = waitCountReg + WAIT_WIDTH'(1);
        end

        instrCountNext = retire ? instrCountReg + COUNT_WIDTH'(1) : instrCountReg;
    end

    // State, instruction register and counters; reset abandons any instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg      <= FETCH;
            irReg         <= '0;
            waitCountReg  <= '0;
            instrCountReg <= '0;
        end else begin
            stateReg      <= stateNext;
            irReg         <= irNext;
            waitCountReg  <= waitCountNext;
            instrCountReg <= instrCountNext;
        end
    end

    // Reset silences every strobe and select in the same cycle it is asserted.
    always_comb begin
        bus.aluSelect  = aluRaw      && !reset;
        bus.regSelect  = regRaw      && !reset;
        bus.immSelect  = immRaw      && !reset;
        bus.dataSelect = dataRaw     && !reset;
        bus.muxSelect  = muxRaw      && !reset;
        bus.jumpSelect = jumpRaw     && !reset;
        bus.memRead    = memReadRaw  && !reset;
        bus.memWrite   = memWriteRaw && !reset;
        bus.irWrite    = irWriteRaw  && !reset;
        bus.pcWrite    = pcWriteRaw  && !reset;
        bus.regWrite   = regWriteRaw && !reset;
        bus.trap       = (stateReg == TRAP);
        bus.state      = stateReg;
        bus.instrCount = instrCountReg;
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for the multi-cycle control unit: each instruction's
// expected per-cycle trace is queued as it is issued and popped as the DUT runs.
module tb_multicycle_control_unit;
    localparam logic [11:0] ALU = 12'h800, REG = 12'h400, IMM = 12'h200, DAT = 12'h100;
    localparam logic [11:0] MUX = 12'h080, JMP = 12'h040, MRD = 12'h020, MWR = 12'h010;
    localparam logic [11:0] IRW = 12'h008, PCW = 12'h004, RGW = 12'h002, TRP = 12'h001;

    typedef struct {
        logic        rdy;
        logic [2:0]  st;
        logic [11:0] sig;
        bit          retire;
    } entryT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    entryT sb[$];
    logic [15:0] expCount = '0;
    int compared = 0;
    int mismatched = 0;

    multicycle_control_unit_if #(.OPCODE_WIDTH(3), .COUNT_WIDTH(16)) bus ();

    multicycle_control_unit #(.OPCODE_WIDTH(3), .MEM_TIMEOUT(16), .COUNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] observed();
        return {bus.aluSelect, bus.regSelect, bus.immSelect, bus.dataSelect,
                bus.muxSelect, bus.jumpSelect, bus.memRead, bus.memWrite,
                bus.irWrite, bus.pcWrite, bus.regWrite, bus.trap};
    endfunction

    function automatic void pushE(logic rdy, logic [2:0] st, logic [11:0] sig, bit ret);
        entryT e;
        e.rdy = rdy; e.st = st; e.sig = sig; e.retire = ret;
        sb.push_back(e);
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction.
    function automatic void buildInstr(logic [2:0] op, int fWait, int mWait);
        for (int i = 0; i < fWait; i++) pushE(1'b0, 3'd0, MRD, 0);
        pushE(1'b1, 3'd0, MRD | IRW | PCW, 0);
        pushE(1'b1, 3'd1, 12'h000, op == 3'b000);
        case (op)
            3'b011: pushE(1'b1, 3'd2, PCW | JMP, 1);
            3'b100: begin pushE(1'b1, 3'd2, REG, 0);       pushE(1'b1, 3'd4, REG | RGW, 1); end
            3'b101: begin pushE(1'b1, 3'd2, IMM, 0);       pushE(1'b1, 3'd4, IMM | RGW, 1); end
            3'b110: begin pushE(1'b1, 3'd2, REG | ALU, 0); pushE(1'b1, 3'd4, REG | ALU | RGW, 1); end
            3'b001: begin
                pushE(1'b1, 3'd2, IMM, 0);
                for (int i = 0; i < mWait; i++) pushE(1'b0, 3'd3, IMM | MUX | MRD, 0);
                pushE(1'b1, 3'd3, IMM | MUX | MRD, 0);
                pushE(1'b1, 3'd4, IMM | DAT | RGW, 1);
            end
            3'b010: begin
                pushE(1'b1, 3'd2, IMM, 0);
                for (int i = 0; i < mWait; i++) pushE(1'b0, 3'd3, IMM | MUX | MWR, 0);
                pushE(1'b1, 3'd3, IMM | MUX | MWR, 1);
            end
            default: ;
        endcase
    endfunction

    // Drive each queued cycle, compare mid-cycle, advance one clock.
    task automatic playQueue(output int cycles);
        entryT e;
        logic [11:0] got;
        cycles = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.memReady = e.rdy;
            @(negedge clk);
            got = observed();
            compared++;
            if (bus.state !== e.st || got !== e.sig) begin
                mismatched++;
                $display("FAIL trace cycle %0d: got state=%0d ctl=%03h, want state=%0d ctl=%03h",
                         cycles, bus.state, got, e.st, e.sig);
            end
            if (e.retire) expCount++;
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    task automatic checkCount(string name);
        compared++;
        if (bus.instrCount !== expCount) begin
            mismatched++;
            $display("FAIL %s instrCount: got %0d, want %0d", name, bus.instrCount, expCount);
        end
    endtask

    task automatic runInstr(logic [2:0] op, int fWait, int mWait);
        int c;
        bus.opcode = op;
        buildInstr(op, fWait, mWait);
        playQueue(c);
        checkCount("instr");
        $display("instr op=%03b fetchWait=%0d memWait=%0d cycles=%0d count=%0d",
                 op, fWait, mWait, c, bus.instrCount);
    endtask

    task automatic doReset();
        reset = 1'b1;
        bus.memReady = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        expCount = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.memReady = 1'b1;
        bus.opcode = 3'b100;
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if (bus.state !== 3'd0 || observed() !== 12'h000 || bus.instrCount !== 16'd0) begin
            mismatched++;
            $display("FAIL reset: got state=%0d ctl=%03h count=%0d, want 0/000/0",
                     bus.state, observed(), bus.instrCount);
        end
        $display("reset state=%0d ctl=%03h count=%0d", bus.state, observed(), bus.instrCount);
        @(posedge clk); #1;
        reset = 1'b0;
        expCount = '0;
    endtask

    task automatic test_add();
        runInstr(3'b100, 0, 0);
    endtask

    task automatic test_lw_wait();
        runInstr(3'b001, 0, 3);
    endtask

    task automatic test_sequence();
        doReset();
        runInstr(3'b010, 0, 0);
        runInstr(3'b011, 0, 0);
        runInstr(3'b110, 0, 0);
        runInstr(3'b000, 0, 0);
        compared++;
        if (bus.instrCount !== 16'd4) begin
            mismatched++;
            $display("FAIL sequence instrCount: got %0d, want 4", bus.instrCount);
        end
    endtask

    task automatic test_illegal();
        int c;
        doReset();
        bus.opcode = 3'b111;
        pushE(1'b1, 3'd0, MRD | IRW | PCW, 0);
        pushE(1'b1, 3'd1, 12'h000, 0);
        for (int i = 0; i < 10; i++) pushE(1'b1, 3'd5, TRP, 0);
        playQueue(c);
        $display("illegal op=111 cycles=%0d trap=%0b", c, bus.trap);
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if ((observed() & ~TRP) !== 12'h000) begin
            mismatched++;
            $display("FAIL illegal strobes under reset: got %03h, want 000", observed() & ~TRP);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        expCount = '0;
        @(negedge clk);
        compared++;
        if (bus.state !== 3'd0 || bus.trap !== 1'b0) begin
            mismatched++;
            $display("FAIL illegal recovery: got state=%0d trap=%0b, want 0/0", bus.state, bus.trap);
        end
        checkCount("illegal");
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int c;
        doReset();
        bus.opcode = 3'b000;
        for (int i = 0; i < 16; i++) pushE(1'b0, 3'd0, MRD, 0);
        pushE(1'b0, 3'd5, TRP, 0);
        pushE(1'b1, 3'd5, TRP, 0);
        playQueue(c);
        $display("timeout memReady low 16 cycles -> trap=%0b", bus.trap);
        doReset();
        runInstr(3'b000, 15, 0);
        runInstr(3'b101, 2, 0);
    endtask

    task automatic test_reset_mid();
        int c;
        doReset();
        bus.opcode = 3'b010;
        pushE(1'b1, 3'd0, MRD | IRW | PCW, 0);
        pushE(1'b1, 3'd1, 12'h000, 0);
        pushE(1'b1, 3'd2, IMM, 0);
        pushE(1'b0, 3'd3, IMM | MUX | MWR, 0);
        pushE(1'b0, 3'd3, IMM | MUX | MWR, 0);
        playQueue(c);
        reset = 1'b1;
        bus.memReady = 1'b1;
        @(negedge clk);
        compared++;
        if (bus.memWrite !== 1'b0 || observed() !== 12'h000) begin
            mismatched++;
            $display("FAIL resetMid strobes: got memWrite=%0b ctl=%03h, want 0/000",
                     bus.memWrite, observed());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.state !== 3'd0) begin
            mismatched++;
            $display("FAIL resetMid state: got %0d, want 0", bus.state);
        end
        checkCount("resetMid");
        $display("resetMid sw abandoned state=%0d count=%0d", bus.state, bus.instrCount);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        doReset();
        for (int i = 0; i < 14; i++) begin
            op = 3'($urandom_range(0, 6));
            runInstr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        bus.opcode = '0;
        bus.memReady = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_sequence();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
